// File: rtl/gate.sv
// Registered 2-bit unsigned A > B comparator with a saturating gt event counter.
// Define GATE_FLAGS_EN to add registered eq/lt flags.
module gate #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       A,
    input  logic [1:0]       B,
    output logic             F,
    output logic             out_valid,
`ifdef GATE_FLAGS_EN
    output logic [CNT_W-1:0] gt_count,
    output logic             eq,
    output logic             lt
`else
    output logic [CNT_W-1:0] gt_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic gt;

    assign gt = (A[1] & ~B[1]) | ((A[1] ~^ B[1]) & A[0] & ~B[0]);

    // A/B are only looked at under in_valid, so X on an idle bus never lands in state
    always_ff @(posedge clk) begin
        if (rst) begin
            F         <= 1'b0;
            out_valid <= 1'b0;
            gt_count  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                F <= gt;
                if (gt && (gt_count != CNT_MAX))
                    gt_count <= gt_count + CNT_ONE;
            end
        end
    end

`ifdef GATE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            eq <= 1'b0;
            lt <= 1'b0;
        end else if (in_valid) begin
            eq <= (A == B);
            lt <= (A < B);
        end
    end
`endif

endmodule

// File: tb/tb_gate.sv
// Directed self-checking bench for gate: reset, exhaustive sweep, valid gap,
// counter saturation (CNT_W = 2 instance) and optional eq/lt flags.
module tb_gate;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] A = 2'd0;
    logic [1:0] B = 2'd0;

    logic       F, out_valid;
    logic [7:0] gt_count;
    logic       F2, out_valid2;
    logic [1:0] gt_count2;
`ifdef GATE_FLAGS_EN
    logic       eq, lt, eq2, lt2;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gate #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .F         (F),
        .out_valid (out_valid),
`ifdef GATE_FLAGS_EN
        .gt_count  (gt_count),
        .eq        (eq),
        .lt        (lt)
`else
        .gt_count  (gt_count)
`endif
    );

    gate #(.CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .F         (F2),
        .out_valid (out_valid2),
`ifdef GATE_FLAGS_EN
        .gt_count  (gt_count2),
        .eq        (eq2),
        .lt        (lt2)
`else
        .gt_count  (gt_count2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [1:0] a, input logic [1:0] b);
        rst = r;
        in_valid = v;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] f_tab;
        logic [7:0]  exp_cnt;
        f_tab = 16'b0111_0011_0001_0000;

        // reset held with a gt sample present
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'd3, 2'd0);
            chk("rst_F", 32'(F), 32'd0);
            chk("rst_ov", 32'(out_valid), 32'd0);
            chk("rst_cnt", 32'(gt_count), 32'd0);
            chk("rst_cnt_sat", 32'(gt_count2), 32'd0);
        end
        step(1'b0, 1'b1, 2'd3, 2'd0);
        chk("post_rst_F", 32'(F), 32'd1);
        chk("post_rst_ov", 32'(out_valid), 32'd1);
        chk("post_rst_cnt", 32'(gt_count), 32'd1);

        // reset mid-stream: no stale result afterward
        step(1'b1, 1'b1, 2'd3, 2'd0);
        chk("mid_rst_F", 32'(F), 32'd0);
        chk("mid_rst_cnt", 32'(gt_count), 32'd0);
        step(1'b0, 1'b0, 2'd0, 2'd0);
        chk("mid_idle_ov", 32'(out_valid), 32'd0);
        chk("mid_idle_F", 32'(F), 32'd0);

        // exhaustive sweep
        step(1'b1, 1'b0, 2'd0, 2'd0);
        exp_cnt = 8'd0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ab;
            ab = 4'(i);
            step(1'b0, 1'b1, ab[3:2], ab[1:0]);
            exp_cnt = exp_cnt + 8'(f_tab[i]);
            chk($sformatf("sweep_F_%0d", i), 32'(F), 32'(f_tab[i]));
            chk($sformatf("sweep_ov_%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("sweep_cnt_%0d", i), 32'(gt_count), 32'(exp_cnt));
        end
        chk("sweep_cnt_end", 32'(gt_count), 32'd6);
        chk("sweep_cnt_sat", 32'(gt_count2), 32'd3);

        // valid gap with opposing data and X on the idle bus
        step(1'b1, 1'b0, 2'd0, 2'd0);
        step(1'b0, 1'b1, 2'd2, 2'd1);
        chk("gap_first_F", 32'(F), 32'd1);
        chk("gap_first_cnt", 32'(gt_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'd0, 2'd3);
            chk("gap_F", 32'(F), 32'd1);
            chk("gap_ov", 32'(out_valid), 32'd0);
            chk("gap_cnt", 32'(gt_count), 32'd1);
        end
        step(1'b0, 1'b0, 2'bxx, 2'bxx);
        chk("gap_x_F", 32'(F), 32'd1);
        chk("gap_x_cnt", 32'(gt_count), 32'd1);
        step(1'b0, 1'b1, 2'd1, 2'd2);
        chk("gap_end_F", 32'(F), 32'd0);
        chk("gap_end_ov", 32'(out_valid), 32'd1);
        chk("gap_end_cnt", 32'(gt_count), 32'd1);

        // saturation on the CNT_W = 2 instance
        step(1'b1, 1'b0, 2'd0, 2'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 2'd3, 2'd0);
            chk($sformatf("sat_cnt_%0d", i), 32'(gt_count2),
                32'((i > 3) ? 3 : i));
            chk($sformatf("wide_cnt_%0d", i), 32'(gt_count), 32'(i));
        end
        step(1'b0, 1'b1, 2'd0, 2'd0);
        chk("sat_hold", 32'(gt_count2), 32'd3);
        chk("sat_F", 32'(F2), 32'd0);

        // flag triple (F is checked in every build)
        step(1'b1, 1'b0, 2'd0, 2'd0);
`ifdef GATE_FLAGS_EN
        chk("rst_eq", 32'(eq), 32'd0);
        chk("rst_lt", 32'(lt), 32'd0);
`endif
        step(1'b0, 1'b1, 2'd1, 2'd1);
        chk("flag11_F", 32'(F), 32'd0);
`ifdef GATE_FLAGS_EN
        chk("flag11_eq", 32'(eq), 32'd1);
        chk("flag11_lt", 32'(lt), 32'd0);
        chk("flag11_1hot", 32'(F + eq + lt), 32'd1);
`endif
        step(1'b0, 1'b1, 2'd0, 2'd2);
        chk("flag02_F", 32'(F), 32'd0);
`ifdef GATE_FLAGS_EN
        chk("flag02_eq", 32'(eq), 32'd0);
        chk("flag02_lt", 32'(lt), 32'd1);
        chk("flag02_1hot", 32'(F + eq + lt), 32'd1);
`endif
        step(1'b0, 1'b1, 2'd3, 2'd2);
        chk("flag32_F", 32'(F), 32'd1);
`ifdef GATE_FLAGS_EN
        chk("flag32_eq", 32'(eq), 32'd0);
        chk("flag32_lt", 32'(lt), 32'd0);
        chk("flag32_1hot", 32'(F + eq + lt), 32'd1);
`endif
        step(1'b0, 1'b0, 2'd0, 2'd0);
`ifdef GATE_FLAGS_EN
        chk("flag_hold_lt", 32'(lt), 32'd0);
        chk("flag_hold_eq", 32'(eq), 32'd0);
`endif
        chk("flag_hold_F", 32'(F), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
